addsub_serial: RTL and testbench

ADDSUB_SERIAL -- requirements
Module: addsub_serial

---
 rtl/addsub_serial_if.sv | 28 ++
 rtl/addsub_serial.sv | 150 +++++++++++++++
 tb/tb_addsub_serial.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/addsub_serial_if.sv
// Handshake and operand/result bundle for addsub_serial.
// The master side issues operations and consumes results; the slave side is the serial adder.
interface addsub_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, abort, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, abort, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_serial.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle, WIDTH/CHUNK cycles per operation.
// Define ADDSUB_SERIAL_SAT_EN for unsigned saturation of the result.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic          clk,
  input logic          rst_n,
  addsub_serial_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // B already inverted for subtract
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
`ifdef ADDSUB_SERIAL_SAT_EN
  logic             sub_q, sub_d;
`endif

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_out, c_msb_in;
  logic [WIDTH-1:0] res_val;

  // NOTE: the ripple chain below uses blocking '=' on purpose: each bit must see the
  // carry produced by the previous iteration within the same evaluation.
  always_comb begin
    a_chunk  = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk  = b_q[idx_q*CHUNK +: CHUNK];
    s_chunk  = '0;
    c_out    = carry_q;
    c_msb_in = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb_in   = c_out;
      s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ c_out;
      c_out      = (a_chunk[i] & b_chunk[i]) | (c_out & (a_chunk[i] ^ b_chunk[i]));
    end
  end

  // NOTE: every *_d gets its hold value first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`ifdef ADDSUB_SERIAL_SAT_EN
    sub_d    = sub_q;
`endif
    res_val  = '0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          idx_d   = '0;
`ifdef ADDSUB_SERIAL_SAT_EN
          sub_d   = bus.sub;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          acc_d[idx_q*CHUNK +: CHUNK] = s_chunk;
          carry_d = c_out;
          idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            res_val = acc_d;
`ifdef ADDSUB_SERIAL_SAT_EN
            // Flags stay raw; only the visible result clamps.
            if (!sub_q && c_out)     res_val = '1;
            else if (sub_q && !c_out) res_val = '0;
`endif
            result_d = res_val;
            cout_d   = c_out;
            ovf_d    = c_out ^ c_msb_in;
            zero_d   = (res_val == '0);
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (bus.abort || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ADDSUB_SERIAL_SAT_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
`ifdef ADDSUB_SERIAL_SAT_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Directed scoreboard bench for addsub_serial (WIDTH=8, CHUNK=2).
// Expected results come from a whole-word arithmetic model pushed at accept time.
module tb_addsub_serial;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(W)) bus();
  addsub_serial #(.WIDTH(W), .CHUNK(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t       e;
    logic [W:0] s;
    logic [W-1:0] bb;
    bb  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    e.r = s[W-1:0];
    e.c = s[W];
    e.v = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
`ifdef ADDSUB_SERIAL_SAT_EN
    if (!sub && s[W])     e.r = '1;
    else if (sub && !s[W]) e.r = '0;
`endif
    e.z = (e.r == '0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int n;
    bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    sb.push_back(model(a, b, sub));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = 1'($urandom_range(0, 1));
    check("busy_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_result(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, 32'(bus.result), 32'(e.r));
      check({tag, "_cout"},   32'(bus.cout),   32'(e.c));
      check({tag, "_ovf"},    32'(bus.ovf),    32'(e.v));
      check({tag, "_zero"},   32'(bus.zero),   32'(e.z));
    end
  endtask

  task automatic handoff(input int hold);
    logic [W+2:0] held;
    held = {bus.result, bus.cout, bus.ovf, bus.zero};
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid",    32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready),  32'd0);
      check("hold_stable",   32'({bus.result, bus.cout, bus.ovf, bus.zero}), 32'(held));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("handoff_valid_low", 32'(bus.out_valid), 32'd0);
    check("handoff_in_ready",  32'(bus.in_ready),  32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_result"},    32'(bus.result),    32'd0);
    check({tag, "_flags"},     32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] va [6] = '{8'h05, 8'h06, 8'h7F, 8'hFF, 8'h80, 8'h80};
    logic [W-1:0] vb [6] = '{8'h03, 8'h07, 8'h01, 8'h01, 8'h01, 8'h80};
    logic         vs [6] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    logic         seen;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic vectors including borrow, signed overflow and wrap-to-zero
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], vs[i]);
      wait_result($sformatf("vec%0d", i));
      handoff(0);
    end

    // Stall in DONE for 5 cycles with a new request pending, then back-to-back accept
    start_op(8'h3C, 8'h15, 1'b0);
    wait_result("stall");
    bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b1; bus.in_valid = 1'b1;
    handoff(5);
    start_op(8'h11, 8'h22, 1'b1);
    wait_result("b2b");
    handoff(0);

    // Abort in RUN after one chunk
    start_op(8'h33, 8'h11, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_run_idle",  32'(bus.in_ready),  32'd1);
    check("abort_run_valid", 32'(bus.out_valid), 32'd0);
    void'(sb.pop_back());
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= bus.out_valid; end
    check("abort_run_never_valid", 32'(seen), 32'd0);
    start_op(8'h09, 8'h04, 1'b1);
    wait_result("after_abort");
    handoff(0);

    // Abort together with out_ready in DONE
    start_op(8'h20, 8'h10, 1'b0);
    wait_result("pre_abort_done");
    bus.abort = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    check("abort_done_valid", 32'(bus.out_valid), 32'd0);
    check("abort_done_idle",  32'(bus.in_ready),  32'd1);

    // Abort in IDLE has no effect on the accept
    bus.abort = 1'b1;
    start_op(8'h0F, 8'h01, 1'b0);
    bus.abort = 1'b0;
    wait_result("abort_idle");
    handoff(0);

    // Reset mid-RUN
    start_op(8'h44, 8'h22, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_run");
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'h00, 8'h01, 1'b1);
    wait_result("after_rst_run");
    handoff(0);

    // Reset mid-DONE with nonzero result and flags
    start_op(8'h7F, 8'h01, 1'b0);
    wait_result("pre_rst_done");
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'h00, 8'h01, 1'b1);
    wait_result("after_rst_done");
    handoff(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
